// File: rtl/mc_pkg.sv
// mc_pkg: shared definitions for the multicycle MIPS main controller.
//   - state_t       : controller FSM states
//   - OP_* / FN_*   : opcode and R-type funct field values
//   - ALU_*         : 3-bit ALU operation codes
//   - SRCB_* / PCS_*: alu_src_b and pc_src mux encodings
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;

endpackage

// File: rtl/mc_control_alu_dec.sv
// alu_dec: combinational R-type funct decoder.
//   i_funct       : instruction funct field [5:0]
//   o_alu_control : ALU operation code (ADD for unsupported funct)
//   o_illegal     : high when funct is not a supported R-type operation
module alu_dec
  import mc_pkg::*;
(
  input  logic [5:0] i_funct,
  output logic [2:0] o_alu_control,
  output logic       o_illegal
);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    o_alu_control = ALU_ADD;
    o_illegal     = 1'b0;
    case (i_funct)
      FN_ADD:  o_alu_control = ALU_ADD;
      FN_SUB:  o_alu_control = ALU_SUB;
      FN_AND:  o_alu_control = ALU_AND;
      FN_OR:   o_alu_control = ALU_OR;
      FN_SLT:  o_alu_control = ALU_SLT;
      default: o_illegal     = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_control.sv
// mc_control: multicycle MIPS main controller.
// Sequences each instruction through FETCH/DECODE/execute/memory/writeback
// states and drives datapath enables, mux selects and the ALU op code.
// Inputs : clk, reset (sync, active-high), opcode[5:0], funct[5:0],
//          zero (ALU zero flag), mem_ready (memory access complete).
// Outputs: pc_en, pc_src[1:0], iord, mem_read, mem_write, ir_write, reg_dst,
//          mem_to_reg, reg_write, alu_src_a, alu_src_b[1:0],
//          alu_control[2:0], illegal_op (one-cycle pulse).
// Build option: define MC_CTRL_BNE_EN to add BNE (opcode 000101) support;
//          when undefined, BNE decodes as an illegal opcode.
module mc_control
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_en,
  output logic [1:0] pc_src,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_control,
  output logic       illegal_op
);

  state_t     r_state;
  state_t     w_next_state;
  logic [2:0] w_exec_alu;
  logic       w_funct_illegal;
  logic       w_branch_take;

  alu_dec u_alu_dec (
    .i_funct       (funct),
    .o_alu_control (w_exec_alu),
    .o_illegal     (w_funct_illegal)
  );

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next_state;
  end

`ifdef MC_CTRL_BNE_EN
  // Branch sense captured in DECODE so BRANCH does not depend on the IR later.
  logic r_is_bne;
  always_ff @(posedge clk) begin
    if (reset)                    r_is_bne <= 1'b0;
    else if (r_state == S_DECODE) r_is_bne <= (opcode == OP_BNE);
  end
  assign w_branch_take = r_is_bne ? ~zero : zero;
`else
  assign w_branch_take = zero;
`endif

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_FETCH:  if (mem_ready) w_next_state = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: w_next_state = S_MEMADR;
          OP_RTYPE:     w_next_state = S_EXEC;
          OP_BEQ:       w_next_state = S_BRANCH;
`ifdef MC_CTRL_BNE_EN
          OP_BNE:       w_next_state = S_BRANCH;
`endif
          OP_ADDI:      w_next_state = S_ADDIEX;
          OP_J:         w_next_state = S_JUMP;
          default:      w_next_state = S_FETCH;
        endcase
      end
      S_MEMADR: w_next_state = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (mem_ready) w_next_state = S_MEMWB;
      S_MEMWB:  w_next_state = S_FETCH;
      S_MEMWR:  if (mem_ready) w_next_state = S_FETCH;
      S_EXEC:   w_next_state = S_ALUWB;
      S_ALUWB:  w_next_state = S_FETCH;
      S_BRANCH: w_next_state = S_FETCH;
      S_ADDIEX: w_next_state = S_ADDIWB;
      S_ADDIWB: w_next_state = S_FETCH;
      S_JUMP:   w_next_state = S_FETCH;
      default:  w_next_state = S_FETCH;
    endcase
  end

  always_comb begin
    pc_en       = 1'b0;
    pc_src      = PCS_ALU;
    iord        = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    reg_write   = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = SRCB_REG;
    alu_control = 3'b000;
    illegal_op  = 1'b0;
    case (r_state)
      S_FETCH: begin
        mem_read    = 1'b1;
        alu_src_b   = SRCB_FOUR;
        alu_control = ALU_ADD;
        ir_write    = mem_ready;
        pc_en       = mem_ready;
      end
      S_DECODE: begin
        alu_src_b   = SRCB_IMM_SH;
        alu_control = ALU_ADD;
        case (opcode)
          OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J: illegal_op = 1'b0;
`ifdef MC_CTRL_BNE_EN
          OP_BNE:  illegal_op = 1'b0;
`endif
          default: illegal_op = 1'b1;
        endcase
      end
      S_MEMADR, S_ADDIEX: begin
        alu_src_a   = 1'b1;
        alu_src_b   = SRCB_IMM;
        alu_control = ALU_ADD;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      S_EXEC: begin
        alu_src_a   = 1'b1;
        alu_control = w_exec_alu;
        illegal_op  = w_funct_illegal;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a   = 1'b1;
        alu_control = ALU_SUB;
        pc_src      = PCS_ALUOUT;
        pc_en       = w_branch_take;
      end
      S_ADDIWB: reg_write = 1'b1;
      S_JUMP: begin
        pc_src = PCS_JUMP;
        pc_en  = 1'b1;
      end
      default: ;
    endcase
    // Reset overrides the decode so an interrupted instruction cannot
    // issue a write or enable during the reset cycle itself.
    if (reset) begin
      pc_en       = 1'b0;
      pc_src      = PCS_ALU;
      iord        = 1'b0;
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      ir_write    = 1'b0;
      reg_dst     = 1'b0;
      mem_to_reg  = 1'b0;
      reg_write   = 1'b0;
      alu_src_a   = 1'b0;
      alu_src_b   = SRCB_REG;
      alu_control = ALU_ADD;
      illegal_op  = 1'b0;
    end
  end

endmodule
